result_serializer: RTL and testbench

//  Output stage downstream of matrix_mult: captures the 3x3 result matrix C (9 x 18-bit)
//  and streams it byte-by-byte on the 8-bit dedicated output bus with a valid/ready handshake.

---
 rtl/result_serializer_if.sv | 12 +
 rtl/result_serializer.sv | 173 +++++++++++++++++
 tb/tb_result_serializer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/result_serializer_if.sv
// Byte-wide valid/ready output bus carrying the serialized result stream.
// The master drives data/valid and the slave answers with ready.
interface result_serializer_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/result_serializer.sv
// Captures the 3x3 result matrix and streams it element by element, LSB byte first,
// over a valid/ready bus; raises done after the last byte until enable drops.
module result_serializer #(
    parameter int N_ELEM = 9,
    parameter int ELEM_W = 18,
    parameter int OUT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [N_ELEM*ELEM_W-1:0] c_flat,
    result_serializer_if.master      out_if,
    output logic                     done
);
    localparam int BYTES_PER = (ELEM_W + OUT_W - 1) / OUT_W;
    localparam int ECW       = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int BCW       = (BYTES_PER > 1) ? $clog2(BYTES_PER) : 1;
    localparam logic [ECW-1:0] LAST_ELEM = ECW'(N_ELEM - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [ECW-1:0]             elem_cnt_q, elem_cnt_d;
    logic [BCW-1:0]             byte_cnt_q, byte_cnt_d;
    logic [N_ELEM*ELEM_W-1:0]   shadow_q, shadow_d;
    logic [OUT_W-1:0]           out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic                       done_q, done_d;
    logic [ECW-1:0]             elem_nxt_s;
    logic [BCW-1:0]             byte_nxt_s;
    logic                       xfer_s;

    // Byte bsel of element elem, upper bits of the final byte zero-padded.
    function automatic logic [OUT_W-1:0] get_byte(
        input logic [N_ELEM*ELEM_W-1:0] vec,
        input logic [ECW-1:0]           elem,
        input logic [BCW-1:0]           bsel
    );
        logic [ELEM_W-1:0]           e;
        logic [BYTES_PER*OUT_W-1:0]  e_pad;
        logic [OUT_W-1:0]            b;
        e = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            if (elem == ECW'(k)) begin
                e = vec[k*ELEM_W +: ELEM_W];
            end
        end
        e_pad = '0;
        e_pad[ELEM_W-1:0] = e;
        b = '0;
        for (int j = 0; j < BYTES_PER; j++) begin
            if (bsel == BCW'(j)) begin
                b = e_pad[j*OUT_W +: OUT_W];
            end
        end
        return b;
    endfunction

    assign xfer_s = out_valid_q & out_if.ready;

    // Position of the byte that follows the one currently on the bus.
    always_comb begin
        elem_nxt_s = elem_cnt_q;
        byte_nxt_s = byte_cnt_q + 1'b1;
        if (byte_cnt_q == LAST_BYTE) begin
            byte_nxt_s = '0;
            elem_nxt_s = elem_cnt_q + 1'b1;
        end else begin
            elem_nxt_s = elem_cnt_q;
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = done_q;
        case (state_q)
            ST_IDLE: begin
                done_d     = 1'b0;
                elem_cnt_d = '0;
                byte_cnt_d = '0;
                if (enable) begin
                    state_d     = ST_SEND;
                    shadow_d    = c_flat;
                    out_valid_d = 1'b1;
                    out_data_d  = get_byte(c_flat, '0, '0);
                end else begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                end
            end
            ST_SEND: begin
                // Abort wins over a transfer landing on the same edge.
                if (!enable) begin
                    state_d     = ST_IDLE;
                    elem_cnt_d  = '0;
                    byte_cnt_d  = '0;
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    done_d      = 1'b0;
                end else if (xfer_s) begin
                    if ((elem_cnt_q == LAST_ELEM) && (byte_cnt_q == LAST_BYTE)) begin
                        state_d     = ST_DONE;
                        elem_cnt_d  = '0;
                        byte_cnt_d  = '0;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        done_d      = 1'b1;
                    end else begin
                        elem_cnt_d = elem_nxt_s;
                        byte_cnt_d = byte_nxt_s;
                        out_data_d = get_byte(shadow_q, elem_nxt_s, byte_nxt_s);
                    end
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                out_valid_d = 1'b0;
                out_data_d  = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end else begin
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                elem_cnt_d  = '0;
                byte_cnt_d  = '0;
                out_valid_d = 1'b0;
                out_data_d  = '0;
                done_d      = 1'b0;
            end
        endcase
    end

    // State, counter, capture and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            elem_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign out_if.data  = out_data_q;
    assign out_if.valid = out_valid_q;
    assign done         = done_q;
endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: byte order, backpressure, abort, reset and capture.
module tb_result_serializer;
    logic          clk;
    logic          reset;
    logic          enable;
    logic [161:0]  c_flat;
    logic          done;
    logic [17:0]   c_mem [9];
    int            checks;
    int            failures;

    result_serializer_if #(.OUT_W(8)) out_if ();

    result_serializer #(.N_ELEM(9), .ELEM_W(18), .OUT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .c_flat (c_flat),
        .out_if (out_if),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int idx);
        logic [17:0] e;
        e = c_mem[idx / 3];
        case (idx % 3)
            0:       return e[7:0];
            1:       return e[15:8];
            2:       return {6'b000000, e[17:16]};
            default: return 8'h00;
        endcase
    endfunction

    task automatic load_c();
        for (int k = 0; k < 9; k++) c_flat[k*18 +: 18] = c_mem[k];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int idx;
        int cyc;
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        enable       = 1'b0;
        c_flat       = '0;
        out_if.ready = 1'b0;
        for (int k = 0; k < 9; k++) c_mem[k] = 18'h00000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst_valid", {31'd0, out_if.valid}, 32'd0);
        check("rst_data",  {24'd0, out_if.data},  32'd0);
        check("rst_done",  {31'd0, done},         32'd0);

        // Mixed values, ready held high: latency and byte order.
        c_mem[0] = 18'h3A5C3;
        for (int k = 1; k < 9; k++) c_mem[k] = 18'(k);
        load_c();
        enable       = 1'b1;
        out_if.ready = 1'b1;
        tick();
        check("t2_first_lit", {24'd0, out_if.data}, 32'h000000C3);
        for (int b = 0; b < 27; b++) begin
            if (b == 1) check("t2_second_lit", {24'd0, out_if.data}, 32'h000000A5);
            if (b == 2) check("t2_third_lit",  {24'd0, out_if.data}, 32'h00000003);
            check($sformatf("t2_valid[%0d]", b), {31'd0, out_if.valid}, 32'd1);
            check($sformatf("t2_data[%0d]", b),  {24'd0, out_if.data},  {24'd0, exp_byte(b)});
            check($sformatf("t2_nodone[%0d]", b), {31'd0, done}, 32'd0);
            tick();
        end
        check("t2_done",       {31'd0, done},         32'd1);
        check("t2_done_valid", {31'd0, out_if.valid}, 32'd0);
        check("t2_done_data",  {24'd0, out_if.data},  32'd0);
        repeat (3) tick();
        check("t2_done_hold",  {31'd0, done},         32'd1);
        check("t2_no_restart", {31'd0, out_if.valid}, 32'd0);
        enable = 1'b0;
        tick();
        check("t2_done_clear", {31'd0, done}, 32'd0);

        // All ones, with c_flat cleared one cycle after capture.
        for (int k = 0; k < 9; k++) c_mem[k] = 18'h3FFFF;
        load_c();
        enable = 1'b1;
        tick();
        c_flat = '0;
        for (int b = 0; b < 27; b++) begin
            check($sformatf("t3_data[%0d]", b), {24'd0, out_if.data}, {24'd0, exp_byte(b)});
            if ((b % 3) == 2) check($sformatf("t3_b2[%0d]", b), {24'd0, out_if.data}, 32'h00000003);
            tick();
        end
        check("t3_done", {31'd0, done}, 32'd1);
        enable = 1'b0;
        tick();

        // Backpressure: ready pattern 1,0,0 repeating.
        c_mem[0] = 18'h3A5C3;
        for (int k = 1; k < 9; k++) c_mem[k] = 18'(k);
        load_c();
        enable = 1'b1;
        tick();
        idx = 0;
        cyc = 0;
        while ((idx < 27) && (cyc < 200)) begin
            check($sformatf("t4_valid[%0d]", cyc), {31'd0, out_if.valid}, 32'd1);
            check($sformatf("t4_data[%0d]", cyc),  {24'd0, out_if.data},  {24'd0, exp_byte(idx)});
            out_if.ready = ((cyc % 3) == 0);
            @(posedge clk);
            if (out_if.ready) idx++;
            @(negedge clk);
            cyc++;
        end
        check("t4_xfers",  idx,        27);
        check("t4_cycles", cyc,        79);
        check("t4_done",   {31'd0, done}, 32'd1);
        out_if.ready = 1'b1;
        enable = 1'b0;
        tick();

        // Abort after 10 transfers; enable drop wins over a ready transfer.
        enable = 1'b1;
        tick();
        for (int b = 0; b < 10; b++) begin
            check($sformatf("t5_data[%0d]", b), {24'd0, out_if.data}, {24'd0, exp_byte(b)});
            tick();
        end
        enable = 1'b0;
        tick();
        check("t5_valid", {31'd0, out_if.valid}, 32'd0);
        check("t5_data",  {24'd0, out_if.data},  32'd0);
        for (int i = 0; i < 25; i++) begin
            check($sformatf("t5_nodone[%0d]", i), {31'd0, done}, 32'd0);
            tick();
        end
        enable = 1'b1;
        tick();
        check("t5_restart", {24'd0, out_if.data}, 32'h000000C3);

        // Asynchronous reset mid-stream, then restart from the top.
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        repeat (5) tick();
        check("t1_pre_data", {24'd0, out_if.data}, {24'd0, exp_byte(5)});
        #2 reset = 1'b1;
        #1;
        check("t1_valid", {31'd0, out_if.valid}, 32'd0);
        check("t1_done",  {31'd0, done},         32'd0);
        check("t1_data",  {24'd0, out_if.data},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t1_restart_valid", {31'd0, out_if.valid}, 32'd1);
        check("t1_restart_data",  {24'd0, out_if.data},  32'h000000C3);
        tick();
        check("t1_restart_b1",    {24'd0, out_if.data},  32'h000000A5);
        enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
